unit_deploy_scheduler: RTL and testbench

- Sits between the player button decoder and a bank of NUM_SLOTS unit slots.
- Owns the gold balance and validates purchases. Picks the lowest-index free slot and drives that slot's purchase strobe together with exactly one type select. Confirms that the slot came alive, and refunds the cost if it did not.
- Also generates the shared move and damage tick strobes for all slots.

---
 rtl/game_pkg.sv | 29 ++
 rtl/unit_deploy_scheduler_if.sv | 38 +++
 rtl/game_tick_gen.sv | 54 +++++
 rtl/unit_deploy_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_unit_deploy_scheduler.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg : unit type codes, default costs and scheduler FSM encodings
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package game_pkg;

  localparam logic [1:0] UT_DEAD = 2'b00;
  localparam logic [1:0] UT_1    = 2'b01;
  localparam logic [1:0] UT_2    = 2'b10;
  localparam logic [1:0] UT_3    = 2'b11;

  localparam int COST1_DEF = 10;
  localparam int COST2_DEF = 20;
  localparam int COST3_DEF = 40;
  localparam int GOLD_MAX  = 255;

  typedef enum logic [4:0] {
    ST_IDLE     = 5'b00001,
    ST_CHECK    = 5'b00010,
    ST_ISSUE    = 5'b00100,
    ST_CONFIRM  = 5'b01000,
    ST_COOLDOWN = 5'b10000
  } state_t;

endpackage

`default_nettype wire

// File: rtl/unit_deploy_scheduler_if.sv
// ---------------------------------------------------------------------------
// unit_deploy_scheduler_if : button requests, slot status and deploy strobes
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface unit_deploy_scheduler_if #(
  parameter int NUM_SLOTS = 4
);
  logic                   leftSCEN;
  logic                   rightSCEN;
  logic                   downSCEN;
  logic [2*NUM_SLOTS-1:0] slotTypes;
  logic [NUM_SLOTS-1:0]   purchase;
  logic                   deployL;
  logic                   deployR;
  logic                   deployD;
  logic                   moveSCEN;
  logic                   damageSCEN;
  logic [7:0]             gold;
  logic                   busy;
  logic                   reject;
  logic                   deployed;

  modport master (
    output leftSCEN, rightSCEN, downSCEN, slotTypes,
    input  purchase, deployL, deployR, deployD, moveSCEN, damageSCEN,
    input  gold, busy, reject, deployed
  );

  modport slave (
    input  leftSCEN, rightSCEN, downSCEN, slotTypes,
    output purchase, deployL, deployR, deployD, moveSCEN, damageSCEN,
    output gold, busy, reject, deployed
  );
endinterface

`default_nettype wire

// File: rtl/game_tick_gen.sv
// ---------------------------------------------------------------------------
// game_tick_gen : shared move/damage tick strobes and gold income pulse
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module game_tick_gen #(
  parameter int MOVE_DIV      = 64,
  parameter int DMG_OFFSET    = 32,
  parameter int INCOME_PERIOD = 1000
) (
  input  wire logic clk,
  input  wire logic reset,
  output logic      moveSCEN,
  output logic      damageSCEN,
  output logic      incomePulse
);

  localparam int MW = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
  localparam int IW = (INCOME_PERIOD > 1) ? $clog2(INCOME_PERIOD) : 1;

  logic [MW-1:0] move_cnt_q, move_cnt_d;
  logic [IW-1:0] inc_cnt_q, inc_cnt_d;
  logic          move_q, move_d, dmg_q, dmg_d;

  // Strobes are registered against the next count so they line up with it.
  always_comb begin
    move_cnt_d = (move_cnt_q == MW'(MOVE_DIV - 1)) ? '0 : move_cnt_q + 1'b1;
    inc_cnt_d  = (inc_cnt_q == IW'(INCOME_PERIOD - 1)) ? '0 : inc_cnt_q + 1'b1;
    move_d     = (move_cnt_d == MW'(MOVE_DIV - 1));
    dmg_d      = (move_cnt_d == MW'(DMG_OFFSET));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      move_cnt_q <= '0;
      inc_cnt_q  <= '0;
      move_q     <= 1'b0;
      dmg_q      <= 1'b0;
    end else begin
      move_cnt_q <= move_cnt_d;
      inc_cnt_q  <= inc_cnt_d;
      move_q     <= move_d;
      dmg_q      <= dmg_d;
    end
  end

  assign moveSCEN    = move_q;
  assign damageSCEN  = dmg_q;
  assign incomePulse = (inc_cnt_q == IW'(INCOME_PERIOD - 1));

endmodule

`default_nettype wire

// File: rtl/unit_deploy_scheduler.sv
// ---------------------------------------------------------------------------
// unit_deploy_scheduler : gold bookkeeping, slot allocation and deploy FSM
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module unit_deploy_scheduler
  import game_pkg::*;
#(
  parameter int NUM_SLOTS     = 4,
  parameter int COST1         = COST1_DEF,
  parameter int COST2         = COST2_DEF,
  parameter int COST3         = COST3_DEF,
  parameter int GOLD_INIT     = 50,
  parameter int INCOME_PERIOD = 1000,
  parameter int MOVE_DIV      = 64,
  parameter int DMG_OFFSET    = 32,
  parameter int CONFIRM_MAX   = 4,
  parameter int COOLDOWN      = 16
) (
  input wire logic clk,
  input wire logic reset,
  unit_deploy_scheduler_if.slave bus
);

  localparam int SW = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int WW = (CONFIRM_MAX > 1) ? $clog2(CONFIRM_MAX) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  state_t               state_q, state_d;
  logic [1:0]           type_q, type_d;
  logic [7:0]           cost_q, cost_d, gold_q, gold_d;
  logic [SW-1:0]        slot_q, slot_d, free_idx;
  logic [WW-1:0]        wait_q, wait_d;
  logic [CW-1:0]        cool_q, cool_d;
  logic [NUM_SLOTS-1:0] purchase_q, purchase_d;
  logic                 dep_l_q, dep_l_d, dep_r_q, dep_r_d, dep_d_q, dep_d_d;
  logic                 reject_q, reject_d, deployed_q, deployed_d;
  logic                 free_found, income;
  logic [1:0]           n_req;
  logic [7:0]           debit, refund;
  logic [10:0]          gold_sum;
  logic [1:0]           slot_type [NUM_SLOTS];

  game_tick_gen #(
    .MOVE_DIV      (MOVE_DIV),
    .DMG_OFFSET    (DMG_OFFSET),
    .INCOME_PERIOD (INCOME_PERIOD)
  ) u_tick (
    .clk         (clk),
    .reset       (reset),
    .moveSCEN    (bus.moveSCEN),
    .damageSCEN  (bus.damageSCEN),
    .incomePulse (income)
  );

  for (genvar g = 0; g < NUM_SLOTS; g++) begin : g_unpack
    assign slot_type[g] = bus.slotTypes[2*g +: 2];
  end

  // Descending scan so the lowest free index is the one left standing.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (slot_type[i] == UT_DEAD) begin
        free_found = 1'b1;
        free_idx   = SW'(i);
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    cost_d     = cost_q;
    slot_d     = slot_q;
    wait_d     = wait_q;
    cool_d     = cool_q;
    purchase_d = '0;
    dep_l_d    = 1'b0;
    dep_r_d    = 1'b0;
    dep_d_d    = 1'b0;
    reject_d   = 1'b0;
    deployed_d = 1'b0;
    debit      = 8'd0;
    refund     = 8'd0;
    n_req      = {1'b0, bus.leftSCEN} + {1'b0, bus.rightSCEN} + {1'b0, bus.downSCEN};
    case (state_q)
      ST_IDLE: begin
        if (n_req == 2'd1) begin
          state_d = ST_CHECK;
          if (bus.leftSCEN) begin
            type_d = UT_1;
            cost_d = 8'(COST1);
          end else if (bus.rightSCEN) begin
            type_d = UT_2;
            cost_d = 8'(COST2);
          end else begin
            type_d = UT_3;
            cost_d = 8'(COST3);
          end
        end else if (n_req != 2'd0) begin
          reject_d = 1'b1;
        end
      end
      ST_CHECK: begin
        if (gold_q >= cost_q && free_found) begin
          state_d    = ST_ISSUE;
          slot_d     = free_idx;
          purchase_d = NUM_SLOTS'(1) << free_idx;
          dep_l_d    = (type_q == UT_1);
          dep_r_d    = (type_q == UT_2);
          dep_d_d    = (type_q == UT_3);
        end else begin
          state_d  = ST_COOLDOWN;
          reject_d = 1'b1;
          cool_d   = '0;
        end
      end
      ST_ISSUE: begin
        debit   = cost_q;
        state_d = ST_CONFIRM;
        wait_d  = '0;
      end
      ST_CONFIRM: begin
        if (slot_type[slot_q] != UT_DEAD) begin
          deployed_d = 1'b1;
          state_d    = ST_COOLDOWN;
          cool_d     = '0;
        end else if (wait_q == WW'(CONFIRM_MAX - 1)) begin
          refund   = cost_q;
          reject_d = 1'b1;
          state_d  = ST_COOLDOWN;
          cool_d   = '0;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_COOLDOWN: begin
        if (cool_q == CW'(COOLDOWN - 1)) state_d = ST_IDLE;
        else                             cool_d  = cool_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Debit, refund and income can land together; clamp once afterwards.
    gold_sum = {3'b0, gold_q} + {3'b0, refund} + {10'b0, income};
    if (gold_sum < {3'b0, debit})             gold_d = 8'd0;
    else if (gold_sum - {3'b0, debit} > 11'(GOLD_MAX)) gold_d = 8'(GOLD_MAX);
    else                                      gold_d = 8'(gold_sum - {3'b0, debit});
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      type_q     <= UT_DEAD;
      cost_q     <= 8'd0;
      gold_q     <= 8'(GOLD_INIT);
      slot_q     <= '0;
      wait_q     <= '0;
      cool_q     <= '0;
      purchase_q <= '0;
      dep_l_q    <= 1'b0;
      dep_r_q    <= 1'b0;
      dep_d_q    <= 1'b0;
      reject_q   <= 1'b0;
      deployed_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      cost_q     <= cost_d;
      gold_q     <= gold_d;
      slot_q     <= slot_d;
      wait_q     <= wait_d;
      cool_q     <= cool_d;
      purchase_q <= purchase_d;
      dep_l_q    <= dep_l_d;
      dep_r_q    <= dep_r_d;
      dep_d_q    <= dep_d_d;
      reject_q   <= reject_d;
      deployed_q <= deployed_d;
    end
  end

  assign bus.purchase = purchase_q;
  assign bus.deployL  = dep_l_q;
  assign bus.deployR  = dep_r_q;
  assign bus.deployD  = dep_d_q;
  assign bus.gold     = gold_q;
  assign bus.busy     = (state_q != ST_IDLE);
  assign bus.reject   = reject_q;
  assign bus.deployed = deployed_q;

endmodule

`default_nettype wire

// File: tb/tb_unit_deploy_scheduler.sv
// ---------------------------------------------------------------------------
// tb_unit_deploy_scheduler : directed and random purchases against a model
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_unit_deploy_scheduler;

  localparam int NS       = 4;
  localparam int INC_P    = 1000;
  localparam int CONF_MAX = 4;
  localparam int COOL     = 16;
  localparam int G_INIT   = 50;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  unit_deploy_scheduler_if #(.NUM_SLOTS(NS)) bus ();
  unit_deploy_scheduler_if #(.NUM_SLOTS(NS)) bus2 ();

  unit_deploy_scheduler #(.NUM_SLOTS(NS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // Second instance exercises saturation with a short income period.
  unit_deploy_scheduler #(.NUM_SLOTS(NS), .GOLD_INIT(254), .INCOME_PERIOD(8)) dut_sat (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int gold_exp, gold2_exp, cyc, pend;
  logic [1:0] slots [NS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive_slots();
    for (int i = 0; i < NS; i++) bus.slotTypes[2*i +: 2] = slots[i];
  endtask

  task automatic tick();
    int s;
    @(posedge clk);
    if (!reset) begin
      gold_exp  = G_INIT;
      gold2_exp = 254;
      cyc       = 0;
    end else begin
      s = gold_exp + pend + ((cyc % INC_P == INC_P - 1) ? 1 : 0);
      gold_exp = (s > 255) ? 255 : (s < 0 ? 0 : s);
      s = gold2_exp + ((cyc % 8 == 7) ? 1 : 0);
      gold2_exp = (s > 255) ? 255 : s;
      cyc++;
    end
    pend = 0;
    #1;
    check_eq("gold", bus.gold, gold_exp);
    check_eq("gold_sat", bus2.gold, gold2_exp);
    check_eq("move", bus.moveSCEN, (cyc % 64 == 63));
    check_eq("damage", bus.damageSCEN, (cyc % 64 == 32));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic cooldown();
    for (int k = 1; k <= COOL; k++) begin
      {bus.downSCEN, bus.rightSCEN, bus.leftSCEN} = 3'($urandom_range(0, 7));
      tick();
      check_eq("cool_reject", bus.reject, 1'b0);
      check_eq("cool_busy", bus.busy, (k < COOL));
    end
    {bus.downSCEN, bus.rightSCEN, bus.leftSCEN} = 3'b000;
  endtask

  // req = {down,right,left}; alive_at = CONFIRM cycle in which slot turns alive
  task automatic purchase_txn(input logic [2:0] req, input int alive_at);
    int ty, cost, fidx;
    logic ok;
    drive_slots();
    check_eq("pre_busy", bus.busy, 1'b0);
    {bus.downSCEN, bus.rightSCEN, bus.leftSCEN} = req;
    tick();
    {bus.downSCEN, bus.rightSCEN, bus.leftSCEN} = 3'b000;
    if (req == 3'b000) return;
    if ($countones(req) > 1) begin
      check_eq("multi_reject", bus.reject, 1'b1);
      check_eq("multi_busy", bus.busy, 1'b0);
      tick();
      check_eq("multi_reject_end", bus.reject, 1'b0);
      return;
    end
    check_eq("accept_busy", bus.busy, 1'b1);
    ty   = req[0] ? 1 : (req[1] ? 2 : 3);
    cost = (ty == 1) ? 10 : ((ty == 2) ? 20 : 40);
    fidx = -1;
    for (int i = 0; i < NS; i++) if (fidx < 0 && slots[i] == 2'b00) fidx = i;
    ok = (gold_exp >= cost) && (fidx >= 0);
    tick();
    if (!ok) begin
      check_eq("check_reject", bus.reject, 1'b1);
      check_eq("check_nopurch", bus.purchase, 0);
      cooldown();
      return;
    end
    check_eq("purchase", bus.purchase, 32'(1) << fidx);
    check_eq("deploy_sel", {bus.deployD, bus.deployR, bus.deployL}, 32'(1) << (ty - 1));
    check_eq("issue_reject", bus.reject, 1'b0);
    pend = -cost;
    tick();
    check_eq("purchase_off", bus.purchase, 0);
    for (int w = 0; w < CONF_MAX; w++) begin
      if (w == alive_at) begin
        slots[fidx] = 2'(ty);
        drive_slots();
      end
      if (w == CONF_MAX - 1 && alive_at > w) pend = cost;
      tick();
      if (alive_at <= w) begin
        check_eq("deployed", bus.deployed, 1'b1);
        check_eq("deployed_rej", bus.reject, 1'b0);
        break;
      end else if (w == CONF_MAX - 1) begin
        check_eq("timeout_reject", bus.reject, 1'b1);
        check_eq("timeout_dep", bus.deployed, 1'b0);
      end else begin
        check_eq("confirm_busy", bus.busy, 1'b1);
        check_eq("confirm_dep", bus.deployed, 1'b0);
      end
    end
    cooldown();
  endtask

  initial begin
    int old, guard;
    logic [2:0] r;
    pend  = 0;
    reset = 1'b0;
    {bus.downSCEN, bus.rightSCEN, bus.leftSCEN} = 3'b000;
    {bus2.downSCEN, bus2.rightSCEN, bus2.leftSCEN} = 3'b000;
    bus2.slotTypes = '1;
    for (int i = 0; i < NS; i++) slots[i] = 2'b00;
    drive_slots();
    tick();
    tick();
    check_eq("rst_busy", bus.busy, 1'b0);
    check_eq("rst_purchase", bus.purchase, 0);
    check_eq("rst_deploy", {bus.deployD, bus.deployR, bus.deployL}, 0);
    check_eq("rst_reject", bus.reject, 1'b0);
    check_eq("rst_deployed", bus.deployed, 1'b0);
    check_eq("rst_gold", bus.gold, 50);
    reset = 1'b1;

    purchase_txn(3'b001, 1);
    check_eq("t1_gold", bus.gold, 40);

    do_reset();
    slots[0] = 2'b01; slots[1] = 2'b10; slots[2] = 2'b00; slots[3] = 2'b00;
    purchase_txn(3'b100, 1);
    check_eq("t2_gold", bus.gold, 10);
    purchase_txn(3'b010, 0);
    check_eq("t3_gold", bus.gold, 10);
    for (int i = 0; i < NS; i++) slots[i] = 2'b11;
    purchase_txn(3'b001, 0);
    check_eq("t4_gold", bus.gold, 10);
    purchase_txn(3'b011, 0);

    do_reset();
    for (int i = 0; i < NS; i++) slots[i] = 2'b00;
    purchase_txn(3'b001, 99);
    check_eq("t6_refund_gold", bus.gold, 50);

    // Align the ISSUE cycle with an income wrap.
    guard = 0;
    while (cyc % INC_P != INC_P - 3 && guard < 2 * INC_P) begin
      tick();
      guard++;
    end
    check_eq("align_guard", (guard < 2 * INC_P), 1'b1);
    old = gold_exp;
    purchase_txn(3'b001, 0);
    check_eq("t7_income_debit", bus.gold, 32'(old - 10 + 1));

    for (int i = 0; i < NS; i++) slots[i] = 2'b00;
    drive_slots();
    bus.leftSCEN = 1'b1;
    tick();
    bus.leftSCEN = 1'b0;
    tick();
    pend = -10;
    tick();
    check_eq("mid_busy", bus.busy, 1'b1);
    reset = 1'b0;
    tick();
    check_eq("mid_rst_busy", bus.busy, 1'b0);
    check_eq("mid_rst_gold", bus.gold, 50);
    check_eq("mid_rst_purch", bus.purchase, 0);
    check_eq("mid_rst_deploy", {bus.deployD, bus.deployR, bus.deployL}, 0);
    check_eq("mid_rst_pulses", {bus.reject, bus.deployed}, 0);
    reset = 1'b1;

    for (int k = 0; k < 60; k++) begin
      if (k % 15 == 0) do_reset();
      for (int i = 0; i < NS; i++)
        slots[i] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      r = 3'($urandom_range(1, 7));
      purchase_txn(r, $urandom_range(0, 5));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
